// File: rtl/led_pattern_decoder.sv
// led_pattern_decoder
// Monitors an LED8 bus and works out which of the eight generator patterns is
// playing. It reports that pattern, the position within its cycle, lock
// status, a restart pulse and a loss-of-lock pulse. Each candidate pattern's
// next value is predicted from the previous sample. Candidates that mispredict
// are dropped from the mask.
module led_pattern_decoder #(
   parameter int LOCK_COUNT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid,
   input  logic [7:0] led_in,
   output logic [3:0] pattern_id,
   output logic [3:0] step,
   output logic       locked,
   output logic       err,
   output logic       cycle_done,
   output logic [7:0] cand
);

   localparam logic HUNT  = 1'b0;
   localparam logic TRACK = 1'b1;

   logic       state_q, state_d;
   logic [7:0] prev_q, prev_d;
   logic [3:0] step_q, step_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] cand_q, cand_d;
   logic       locked_q, locked_d;
   logic [3:0] pid_q, pid_d;
   logic       err_q, err_d;
   logic       done_q, done_d;

   logic [7:0] match;
   logic [7:0] start_mask;
   logic       restart;

   // Next value of pattern idx+1 given the previous sample.
   // From 00, every pattern continues with its own start value.
   function automatic logic [7:0] next_pat(input logic [2:0] idx, input logic [7:0] v);
      logic [7:0] r;
      r = 8'h00;
      case (idx)
         3'd0: r = {1'b0, v[7:1]};
         3'd1: r = {v[6:0], 1'b0};
         3'd2: r = (v == 8'hFF) ? 8'h00 : ({1'b0, v[7:1]} | 8'h80);
         3'd3: r = (v == 8'hFF) ? 8'h00 : ({v[6:0], 1'b0} | 8'h01);
         3'd4: r = {v[6:4], 1'b0, 1'b0, v[3:1]};
         3'd5: r = {1'b0, v[7:5], v[2:0], 1'b0};
         3'd6: r = (v == 8'hFF) ? 8'h00 : ({v[6:4], 1'b0, 1'b0, v[3:1]} | 8'h18);
         default: r = (v == 8'hFF) ? 8'h00 : ({1'b0, v[7:5], v[2:0], 1'b0} | 8'h81);
      endcase
      if (v == 8'h00) begin
         case (idx)
            3'd0, 3'd2: r = 8'h80;
            3'd1, 3'd3: r = 8'h01;
            3'd4, 3'd6: r = 8'h18;
            default:    r = 8'h81;
         endcase
      end
      return r;
   endfunction

   // Candidate set for a sample that is a start value. Zero means the sample
   // cannot begin any pattern.
   function automatic logic [7:0] start_cand(input logic [7:0] v);
      logic [7:0] r;
      case (v)
         8'h80:   r = 8'h05;
         8'h01:   r = 8'h0A;
         8'h18:   r = 8'h50;
         8'h81:   r = 8'hA0;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // Per-sample tracking. A failed prediction rescans the same sample as a
   // possible new start.
   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      step_d     = step_q;
      cnt_d      = cnt_q;
      cand_d     = cand_q;
      err_d      = 1'b0;
      done_d     = 1'b0;
      restart    = 1'b0;
      match      = 8'h00;
      start_mask = start_cand(led_in);

      if (valid) begin
         if (state_q == TRACK) begin
            // An unchanged sample means the generator is paused. Treat it as a hold.
            if (led_in != prev_q) begin
               for (int p = 0; p < 8; p++)
                  match[p] = cand_q[p] && (led_in == next_pat(3'(p), prev_q));
               if (match != 8'h00) begin
                  cand_d = match;
                  prev_d = led_in;
                  cnt_d  = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
                  if (prev_q == 8'h00) begin
                     step_d = 4'd0;
                     done_d = locked_q;
                  end else begin
                     step_d = step_q + 4'd1;
                  end
               end else begin
                  err_d   = locked_q;
                  restart = 1'b1;
               end
            end
         end else begin
            restart = 1'b1;
         end

         if (restart) begin
            cand_d = start_mask;
            step_d = 4'd0;
            cnt_d  = 4'd0;
            if (start_mask != 8'h00) begin
               state_d = TRACK;
               prev_d  = led_in;
            end else begin
               state_d = HUNT;
               prev_d  = 8'h00;
            end
         end
      end
   end

   // Lock requires a single surviving candidate plus enough matched advances.
   always_comb begin
      locked_d = (cand_d != 8'h00) && ((cand_d & (cand_d - 8'd1)) == 8'h00)
                 && (cnt_d >= 4'(LOCK_COUNT));
      pid_d = 4'd0;
      if (locked_d) begin
         for (int p = 0; p < 8; p++)
            if (cand_d[p]) pid_d = 4'(p + 1);
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= HUNT;
         prev_q   <= 8'h00;
         step_q   <= 4'd0;
         cnt_q    <= 4'd0;
         cand_q   <= 8'h00;
         locked_q <= 1'b0;
         pid_q    <= 4'd0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         step_q   <= step_d;
         cnt_q    <= cnt_d;
         cand_q   <= cand_d;
         locked_q <= locked_d;
         pid_q    <= pid_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   assign pattern_id = pid_q;
   assign step       = step_q;
   assign locked     = locked_q;
   assign err        = err_q;
   assign cycle_done = done_q;
   assign cand       = cand_q;

endmodule
